// File: rtl/mdu_seq.sv
// Sequential radix-2 restoring divider for 64-bit and word-sized div/rem.
// Takes one request at a time and holds the result until the consumer takes it.
module mdu_seq #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_tag,
    input  logic            flush,
    output logic            busy
);

    localparam int unsigned HALF = XLEN / 2;
    localparam int unsigned CNTW = $clog2(XLEN) + 1;
    localparam logic [CNTW-1:0] LAST_D = CNTW'(XLEN - 1);
    localparam logic [CNTW-1:0] LAST_W = CNTW'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_next;

    logic [CNTW-1:0] cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic            neg_q_q;
    logic            neg_r_q;
    logic            word_q;
    logic            sel_rem_q;

    logic            accept;
    logic            op_uns;
    logic            op_rem;
    logic            op_word;
    logic [XLEN-1:0] a_sel;
    logic [XLEN-1:0] b_sel;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] min_val;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_raw;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic            q_bit;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] res_fix;
    logic [XLEN-1:0] final_res;
    logic            last;

    function automatic logic [XLEN-1:0] sext_w(input logic [HALF-1:0] v);
        return {{HALF{v[HALF-1]}}, v};
    endfunction

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    // Operand width selection, magnitudes and the two early-out cases
    always_comb begin
        op_uns  = in_op[0];
        op_rem  = in_op[1];
        op_word = in_op[2];
        a_sel   = in_a;
        b_sel   = in_b;
        if (op_word) begin
            a_sel = op_uns ? {{HALF{1'b0}}, in_a[HALF-1:0]} : sext_w(in_a[HALF-1:0]);
            b_sel = op_uns ? {{HALF{1'b0}}, in_b[HALF-1:0]} : sext_w(in_b[HALF-1:0]);
        end
        a_neg    = ~op_uns & a_sel[XLEN-1];
        b_neg    = ~op_uns & b_sel[XLEN-1];
        a_mag    = a_neg ? -a_sel : a_sel;
        b_mag    = b_neg ? -b_sel : b_sel;
        min_val  = op_word ? {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}}
                           : {1'b1, {(XLEN - 1){1'b0}}};
        div_zero = (b_sel == '0);
        ovf      = ~op_uns & (a_sel == min_val) & (b_sel == '1);
        special  = div_zero | ovf;
        if (div_zero) begin
            special_raw = op_rem ? a_sel : '1;
        end else begin
            special_raw = op_rem ? '0 : a_sel;
        end
        special_res = op_word ? sext_w(special_raw[HALF-1:0]) : special_raw;
    end

    // One restoring step plus sign fix-up of the step's outcome
    always_comb begin
        shifted   = {rem_q, quo_q[XLEN-1]};
        trial     = shifted - {1'b0, dvs_q};
        q_bit     = ~trial[XLEN];
        rem_nx    = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quo_nx    = {quo_q[XLEN-2:0], q_bit};
        q_fix     = neg_q_q ? -quo_nx : quo_nx;
        r_fix     = neg_r_q ? -rem_nx : rem_nx;
        res_fix   = sel_rem_q ? r_fix : q_fix;
        final_res = word_q ? sext_w(res_fix[HALF-1:0]) : res_fix;
        last      = (cnt_q == (word_q ? LAST_W : LAST_D));
    end

    always_comb begin
        state_next = state_q;
        accept     = in_valid & in_ready & ~flush;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Dividend rides in quo_q; word ops pre-shift it so 32 steps finish the job
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            word_q     <= 1'b0;
            sel_rem_q  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= op_word ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
            dvs_q     <= b_mag;
            neg_q_q   <= a_neg ^ b_neg;
            neg_r_q   <= a_neg;
            word_q    <= op_word;
            sel_rem_q <= op_rem;
            out_tag   <= in_tag;
            if (special) begin
                out_result <= special_res;
            end
        end else if (state_q == CALC) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + CNTW'(1);
            if (last) begin
                out_result <= final_res;
            end
        end
    end

endmodule
